// File: rtl/curl_sponge_core.sv
// rtl/curl_sponge_core.sv - Curl-P sponge engine: chunk absorb, one round per clock, squeezed hash output
module curl_sponge_core #(
    parameter int HASH_LENGTH      = 243,
    parameter int STATE_LENGTH     = 3 * HASH_LENGTH,
    parameter int NUMBER_OF_ROUNDS = 81,
    parameter int RW               = 7
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_first,
    input  logic                     in_last,
    input  logic [2*HASH_LENGTH-1:0] in_data,
    input  logic [RW-1:0]            rounds_i,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*HASH_LENGTH-1:0] out_hash,
    output logic                     busy
);
    localparam int H    = HASH_LENGTH;
    localparam int S    = STATE_LENGTH;
    localparam int STEP = (S - 1) / 2;
    localparam logic [RW-1:0] NR_W = RW'(NUMBER_OF_ROUNDS);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_TRANSFORM = 2'd1,
        ST_OUTPUT    = 2'd2
    } fsm_t;

    fsm_t              fsm_q, fsm_d;
    logic [2*S-1:0]    state_q, state_d;
    logic [RW-1:0]     rcnt_q, rcnt_d;
    logic              last_q, last_d;
    logic [2*S-1:0]    round_next;
    logic [2*H-1:0]    absorb_data;
    logic [RW-1:0]     rounds_eff;

    // Curl S-box on trit codes; a = old[t(k)], b = old[t(k+1)]
    function automatic logic [1:0] curl_lut(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] r;
        r = 2'b00;
        case ({b, a})
            4'b11_11: r = 2'b01;
            4'b11_00: r = 2'b00;
            4'b11_01: r = 2'b11;
            4'b00_11: r = 2'b01;
            4'b00_00: r = 2'b11;
            4'b00_01: r = 2'b00;
            4'b01_11: r = 2'b11;
            4'b01_00: r = 2'b01;
            4'b01_01: r = 2'b00;
            default:  r = 2'b00;
        endcase
        return r;
    endfunction

    // The index walk t(k+1) = t(k) + (S-1)/2 mod S has the closed form k*(S-1)/2 mod S
    for (genvar k = 0; k < S; k++) begin : g_round
        localparam int T0 = (k * STEP) % S;
        localparam int T1 = ((k + 1) * STEP) % S;
        assign round_next[2*k +: 2] = curl_lut(state_q[2*T0 +: 2], state_q[2*T1 +: 2]);
    end

    // 2'b10 is folded to zero on the way in so the state only ever holds legal codes
    always_comb begin
        absorb_data = '0;
        for (int i = 0; i < H; i++) begin
            absorb_data[2*i +: 2] = (in_data[2*i +: 2] == 2'b10) ? 2'b00 : in_data[2*i +: 2];
        end
    end

    assign rounds_eff = (rounds_i == '0 || rounds_i > NR_W) ? NR_W : rounds_i;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            rcnt_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            ST_IDLE:      if (in_valid) fsm_d = ST_TRANSFORM;
            ST_TRANSFORM: if (rcnt_q == RW'(1)) fsm_d = last_q ? ST_OUTPUT : ST_IDLE;
            ST_OUTPUT:    if (out_ready) fsm_d = ST_IDLE;
            default:      fsm_d = ST_IDLE;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        last_d  = last_q;
        case (fsm_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d[2*H-1:0] = absorb_data;
                    if (in_first) state_d[2*S-1:2*H] = '0;
                    rcnt_d = rounds_eff;
                    last_d = in_last;
                end
            end
            ST_TRANSFORM: begin
                state_d = round_next;
                rcnt_d  = rcnt_q - RW'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready  = (fsm_q == ST_IDLE);
        out_valid = (fsm_q == ST_OUTPUT);
        busy      = (fsm_q != ST_IDLE);
        out_hash  = state_q[2*H-1:0];
    end
endmodule

// File: tb/tb_curl_sponge_core.sv
// tb/tb_curl_sponge_core.sv - directed checks of curl_sponge_core against a reference Curl sponge model
module tb_curl_sponge_core;
    localparam int H  = 243;
    localparam int S  = 729;
    localparam int RW = 7;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_first = 1'b0;
    logic             in_last = 1'b0;
    logic [2*H-1:0]   in_data = '0;
    logic [RW-1:0]    rounds_i = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [2*H-1:0]   out_hash;
    logic             busy;

    int total = 0;
    int bad   = 0;

    int ms [S];
    int mcopy [S];
    int lut [11] = '{1, 0, -1, 2, 1, -1, 0, 2, -1, 1, 0};

    curl_sponge_core dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .in_last   (in_last),
        .in_data   (in_data),
        .rounds_i  (rounds_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hash  (out_hash),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2*H-1:0] obs, input logic [2*H-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int dec(input logic [1:0] c);
        if (c == 2'b01) return 1;
        if (c == 2'b11) return -1;
        return 0;
    endfunction

    function automatic logic [1:0] enc(input int v);
        if (v == 1) return 2'b01;
        if (v == -1) return 2'b11;
        return 2'b00;
    endfunction

    // Reference sponge step written the way software Curl does it: iterative index walk, integer LUT
    task automatic model_absorb(input logic [2*H-1:0] d, input bit first, input int rounds);
        int r;
        int t;
        r = (rounds == 0 || rounds > 81) ? 81 : rounds;
        if (first) for (int i = 0; i < S; i++) ms[i] = 0;
        for (int i = 0; i < H; i++) ms[i] = dec(d[2*i +: 2]);
        for (int rr = 0; rr < r; rr++) begin
            for (int i = 0; i < S; i++) mcopy[i] = ms[i];
            t = 0;
            for (int k = 0; k < S; k++) begin
                int a;
                int b;
                a = mcopy[t];
                t = (t < 365) ? t + 364 : t - 365;
                b = mcopy[t];
                ms[k] = lut[a + 4 * b + 5];
            end
        end
    endtask

    function automatic logic [2*H-1:0] model_hash();
        logic [2*H-1:0] h;
        h = '0;
        for (int i = 0; i < H; i++) h[2*i +: 2] = enc(ms[i]);
        return h;
    endfunction

    function automatic logic [2*H-1:0] rand_chunk();
        logic [2*H-1:0] d;
        d = '0;
        for (int i = 0; i < H; i++) begin
            case ($urandom_range(2))
                0: d[2*i +: 2] = 2'b00;
                1: d[2*i +: 2] = 2'b01;
                default: d[2*i +: 2] = 2'b11;
            endcase
        end
        return d;
    endfunction

    task automatic run_job(input string tag, input logic [2*H-1:0] d, input bit first, input bit last,
                           input logic [RW-1:0] rounds, input int exp_lat);
        int n;
        int c;
        n = 0;
        while (!in_ready && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) check({tag, "_ready_timeout"}, in_ready, 1);
        in_valid = 1'b1;
        in_first = first;
        in_last  = last;
        in_data  = d;
        rounds_i = rounds;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({tag, "_inready_busy"}, {in_ready, busy}, 2'b01);
        c = 0;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk);
            #1;
            if (last ? out_valid : in_ready) begin
                c = i;
                break;
            end
        end
        check({tag, "_latency"}, c, exp_lat);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_hs_valid_ready"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        logic [2*H-1:0] ca;
        logic [2*H-1:0] cb;
        logic [2*H-1:0] held;

        // Reset state
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_hash", out_hash, '0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // All-zero chunk, 1/2/3 rounds: all -1, then all +1, then all 0
        run_job("r1", '0, 1'b1, 1'b1, 7'd1, 1);
        check("r1_hash", out_hash, {H{2'b11}});
        handshake("r1");
        run_job("r2", '0, 1'b1, 1'b1, 7'd2, 2);
        check("r2_hash", out_hash, {H{2'b01}});
        handshake("r2");
        run_job("r3", '0, 1'b1, 1'b1, 7'd3, 3);
        check("r3_hash", out_hash, {H{2'b00}});
        handshake("r3");

        // Round-count clamping
        model_absorb('0, 1'b1, 81);
        run_job("r0", '0, 1'b1, 1'b1, 7'd0, 81);
        check("r0_hash", out_hash, model_hash());
        handshake("r0");
        run_job("r100", '0, 1'b1, 1'b1, 7'd100, 81);
        check("r100_hash", out_hash, model_hash());
        handshake("r100");

        // Two-chunk Curl-P-81 with an illegal 2'b10 code folded to zero in chunk B
        ca = rand_chunk();
        cb = rand_chunk();
        cb[2*17 +: 2] = 2'b10;
        model_absorb(ca, 1'b1, 81);
        model_absorb(cb, 1'b0, 81);
        run_job("mcA", ca, 1'b1, 1'b0, 7'd81, 81);
        check("mcA_no_valid", out_valid, 0);
        run_job("mcB", cb, 1'b0, 1'b1, 7'd81, 81);
        check("mcB_hash", out_hash, model_hash());

        // Output stall for 10 cycles
        held = out_hash;
        repeat (10) @(posedge clk);
        #1;
        check("stall_valid_ready_busy", {out_valid, in_ready, busy}, 3'b101);
        check("stall_hash", out_hash, held);
        handshake("stall");
        check("post_hs_hash_kept", out_hash, held);

        // Asynchronous reset mid-transform, then a fresh 27-round job
        in_valid = 1'b1;
        in_first = 1'b1;
        in_last  = 1'b1;
        in_data  = rand_chunk();
        rounds_i = 7'd81;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_in_ready", in_ready, 1);
        check("arst_out_valid", out_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_out_hash", out_hash, '0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        ca = rand_chunk();
        model_absorb(ca, 1'b1, 27);
        run_job("p27", ca, 1'b1, 1'b1, 7'd27, 27);
        check("p27_hash", out_hash, model_hash());
        handshake("p27");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
